// File: rtl/uart_tx_fifo_if.sv
// Push-side handshake, flush control and line/status signals of the buffered UART transmitter.
// master = word producer, slave = uart_tx_fifo.
interface uart_tx_fifo_if #(
    parameter int data_bits = 8,
    parameter int level_w   = 5
) ();
    logic [data_bits-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_flush;
    logic                 tx_serial;
    logic                 tx_busy;
    logic [level_w-1:0]   fifo_level;

    modport master (
        output tx_data, tx_valid, tx_flush,
        input  tx_ready, tx_serial, tx_busy, fifo_level
    );

    modport slave (
        input  tx_data, tx_valid, tx_flush,
        output tx_ready, tx_serial, tx_busy, fifo_level
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready FIFO feeding a start/data/[parity]/stop serialiser.
// Define UART_TX_PARITY_EN to add a parity bit after the data bits (parity_mode: 0 even, 1 odd).
module uart_tx_fifo #(
    parameter int sys_clk_freq    = 16,
    parameter int baud_rate       = 1,
    parameter int data_bits       = 8,
    parameter int stop_bits       = 1,
    parameter int parity_mode     = 0,
    parameter int fifo_depth_log2 = 4
) (
    input  logic          comm_clk,
    input  logic          rst,
    uart_tx_fifo_if.slave bus
);
    localparam int CLKS_PER_BIT = sys_clk_freq / baud_rate;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W        = $clog2(data_bits + 1);
    localparam int DEPTH        = 2 ** fifo_depth_log2;
    localparam int LEVEL_W      = fifo_depth_log2 + 1;

    localparam logic [BAUD_W-1:0]          BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0]          BAUD_ONE   = BAUD_W'(1);
    localparam logic [BIT_W-1:0]           DATA_LAST  = BIT_W'(data_bits - 1);
    localparam logic [BIT_W-1:0]           STOP_LAST  = BIT_W'(stop_bits - 1);
    localparam logic [BIT_W-1:0]           BIT_ONE    = BIT_W'(1);
    localparam logic [LEVEL_W-1:0]         LEVEL_FULL = LEVEL_W'(DEPTH);
    localparam logic [LEVEL_W-1:0]         LEVEL_ONE  = LEVEL_W'(1);
    localparam logic [fifo_depth_log2-1:0] PTR_ONE    = fifo_depth_log2'(1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_fifo: sys_clk_freq / baud_rate must be at least 2");
    end
    if (parity_mode != 0 && parity_mode != 1) begin : g_bad_parity
        $error("uart_tx_fifo: parity_mode must be 0 or 1");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    localparam logic PARITY_ODD = (parity_mode == 1);
    logic r_parity;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t                     r_state;
    logic [BAUD_W-1:0]          r_baud;
    logic [BIT_W-1:0]           r_bit;
    logic [data_bits-1:0]       r_shift;
    logic                       r_serial;
    logic                       r_busy;

    logic [data_bits-1:0]       r_mem [DEPTH];
    logic [fifo_depth_log2-1:0] r_wr_ptr;
    logic [fifo_depth_log2-1:0] r_rd_ptr;
    logic [LEVEL_W-1:0]         r_level;

    logic                       w_full;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_stop_end;
    logic [data_bits-1:0]       w_head;

    // Full blocks pushes even on a pop cycle: no pass-through from a full FIFO.
    assign w_full     = (r_level == LEVEL_FULL);
    assign w_push     = bus.tx_valid && !w_full && !bus.tx_flush;
    assign w_stop_end = (r_state == S_STOP) && (r_baud == BAUD_LAST) && (r_bit == STOP_LAST);
    assign w_pop      = (r_level != '0) && ((r_state == S_IDLE) || w_stop_end);
    assign w_head     = r_mem[r_rd_ptr];

    assign bus.tx_ready   = !w_full;
    assign bus.fifo_level = r_level;
    assign bus.tx_serial  = r_serial;
    assign bus.tx_busy    = r_busy;

    always_ff @(posedge comm_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.tx_data;
        end
    end

    always_ff @(posedge comm_clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (bus.tx_flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LEVEL_ONE;
                2'b01:   r_level <= r_level - LEVEL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge comm_clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_serial <= 1'b1;
            r_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_serial <= 1'b1;
                    r_busy   <= 1'b0;
                    if (w_pop) begin
                        r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
                        r_parity <= (^w_head) ^ PARITY_ODD;
`endif
                        r_baud   <= '0;
                        r_bit    <= '0;
                        r_serial <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud   <= '0;
                        r_bit    <= '0;
                        r_serial <= r_shift[0];
                        r_state  <= S_DATA;
                    end else begin
                        r_baud <= r_baud + BAUD_ONE;
                    end
                end
                S_DATA: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud <= '0;
                        if (r_bit == DATA_LAST) begin
                            r_bit <= '0;
`ifdef UART_TX_PARITY_EN
                            r_serial <= r_parity;
                            r_state  <= S_PARITY;
`else
                            r_serial <= 1'b1;
                            r_state  <= S_STOP;
`endif
                        end else begin
                            r_bit    <= r_bit + BIT_ONE;
                            r_shift  <= r_shift >> 1;
                            r_serial <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_ONE;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud   <= '0;
                        r_serial <= 1'b1;
                        r_state  <= S_STOP;
                    end else begin
                        r_baud <= r_baud + BAUD_ONE;
                    end
                end
`endif
                S_STOP: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud <= '0;
                        if (r_bit == STOP_LAST) begin
                            r_bit <= '0;
                            // Chain straight into the next start bit when more words wait.
                            if (w_pop) begin
                                r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
                                r_parity <= (^w_head) ^ PARITY_ODD;
`endif
                                r_serial <= 1'b0;
                                r_state  <= S_START;
                            end else begin
                                r_serial <= 1'b1;
                                r_busy   <= 1'b0;
                                r_state  <= S_IDLE;
                            end
                        end else begin
                            r_bit <= r_bit + BIT_ONE;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_ONE;
                    end
                end
                default: begin
                    r_serial <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frames on the line are compared against waveforms built from the
// frame format and a queue of accepted words; FIFO full/flush/reset timing checked directly.
module tb_uart_tx_fifo;
    localparam int CPB   = 16;
    localparam int DB    = 8;
    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int STOPB = 2;
    localparam int PMODE = 1;
    localparam int PB    = 1;
`else
    localparam int STOPB = 1;
    localparam int PMODE = 0;
    localparam int PB    = 0;
`endif
    localparam int NBITS = 1 + DB + PB + STOPB;
    localparam int FLEN  = NBITS * CPB;
    localparam time TCLK = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #(TCLK / 2) clk = ~clk;

    uart_tx_fifo_if #(.data_bits(DB), .level_w(5)) bus ();

    uart_tx_fifo #(
        .sys_clk_freq   (16),
        .baud_rate      (1),
        .data_bits      (DB),
        .stop_bits      (STOPB),
        .parity_mode    (PMODE),
        .fifo_depth_log2(4)
    ) dut (
        .comm_clk(clk),
        .rst     (rst),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [DB-1:0] sb[$];

    function automatic logic [FLEN-1:0] exp_frame(input logic [DB-1:0] w);
        logic [NBITS-1:0] bits;
        logic [FLEN-1:0]  f;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < DB; i++) bits[1 + i] = w[i];
        if (PB == 1) bits[1 + DB] = (^w) ^ (PMODE != 0);
        for (int c = 0; c < FLEN; c++) f[c] = bits[c / CPB];
        return f;
    endfunction

    task automatic push_word(input logic [DB-1:0] w, input int max_wait, output bit ok, output time t_acc);
        logic rdy;
        ok    = 1'b0;
        t_acc = 0;
        for (int i = 0; i < max_wait && !ok; i++) begin
            @(negedge clk);
            bus.tx_data  = w;
            bus.tx_valid = 1'b1;
            rdy = bus.tx_ready;
            @(posedge clk);
            if (rdy === 1'b1) begin
                ok    = 1'b1;
                t_acc = $time;
            end
        end
    endtask

    task automatic release_bus();
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic monitor_frames(input int nframes, input int max_gap, input bit want_contig);
        logic [FLEN-1:0] cap;
        logic [FLEN-1:0] exp;
        logic [DB-1:0]   w;
        int  gap;
        bit  seen;
        bit  busy_ok;
        for (int f = 0; f < nframes; f++) begin
            gap  = 0;
            seen = 1'b0;
            while (!seen && gap <= max_gap) begin
                @(negedge clk);
                if (bus.tx_serial === 1'b0) seen = 1'b1;
                else gap++;
            end
            n_tests++;
            if (!seen) begin
                n_fail++;
                $display("FAIL frame_start[%0d]: no start bit after %0d cycles, required a frame", f, gap);
                return;
            end
            cap     = '1;
            cap[0]  = 1'b0;
            busy_ok = (bus.tx_busy === 1'b1);
            for (int c = 1; c < FLEN; c++) begin
                @(negedge clk);
                cap[c] = bus.tx_serial;
                if (bus.tx_busy !== 1'b1) busy_ok = 1'b0;
            end
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL frame_unexpected[%0d]: got frame %h, required no frame", f, cap);
            end else begin
                w   = sb.pop_front();
                exp = exp_frame(w);
                if (cap !== exp) begin
                    n_fail++;
                    $display("FAIL frame_bits[%0d] word %h: got %h, required %h", f, w, cap, exp);
                end
            end
            n_tests++;
            if (!busy_ok) begin
                n_fail++;
                $display("FAIL frame_busy[%0d]: tx_busy dropped during frame, required high", f);
            end
            if (want_contig && f > 0) begin
                n_tests++;
                if (gap != 0) begin
                    n_fail++;
                    $display("FAIL frame_gap[%0d]: got %0d idle cycles, required 0", f, gap);
                end
            end
        end
    endtask

    task automatic check_idle(input int ncyc, input string name);
        int bad = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (bus.tx_serial !== 1'b1 || bus.tx_busy !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s_line: got %0d non-idle cycles, required 0", name, bad);
        end
        n_tests++;
        if (bus.fifo_level !== 5'd0) begin
            n_fail++;
            $display("FAIL %s_level: got %0d, required 0", name, bus.fifo_level);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.tx_serial !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_serial_in_rst: got %b, required 1", bus.tx_serial);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.tx_serial !== 1'b1) begin n_fail++; $display("FAIL reset_serial: got %b, required 1", bus.tx_serial); end
        n_tests++;
        if (bus.tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", bus.tx_busy); end
        n_tests++;
        if (bus.fifo_level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d, required 0", bus.fifo_level); end
        n_tests++;
        if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", bus.tx_ready); end
    endtask

    task automatic test_single(input logic [DB-1:0] w);
        logic [FLEN-1:0] cap;
        logic [FLEN-1:0] exp;
        bit  busy_ok;
        bit  ok;
        time t_acc;
        push_word(w, 4, ok, t_acc);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL single_accept %h: not accepted, required accept", w); end
        @(negedge clk);
        bus.tx_valid = 1'b0;
        n_tests++;
        if (bus.tx_serial !== 1'b1) begin
            n_fail++;
            $display("FAIL single_latency_early: got %b on accept cycle, required 1", bus.tx_serial);
        end
        busy_ok = 1'b1;
        for (int c = 0; c < FLEN; c++) begin
            @(negedge clk);
            cap[c] = bus.tx_serial;
            if (bus.tx_busy !== 1'b1) busy_ok = 1'b0;
        end
        exp = exp_frame(w);
        n_tests++;
        if (cap !== exp) begin n_fail++; $display("FAIL single_frame %h: got %h, required %h", w, cap, exp); end
        n_tests++;
        if (!busy_ok) begin n_fail++; $display("FAIL single_busy %h: tx_busy low inside frame, required high", w); end
        @(negedge clk);
        n_tests++;
        if (bus.tx_serial !== 1'b1 || bus.tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_frame_end: got serial %b busy %b, required 1 0", bus.tx_serial, bus.tx_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [DB-1:0] lead;
        logic [DB-1:0] w;
        bit  ok;
        time t_lead;
        time t_aa;
        time t_x;
        lead = DB'($urandom);
        fork
            monitor_frames(18, 4 * FLEN, 1'b1);
            begin
                push_word(lead, 4, ok, t_lead);
                sb.push_back(lead);
                for (int i = 0; i < 16; i++) begin
                    w = DB'(8'h10 + i);
                    push_word(w, 4, ok, t_x);
                    n_tests++;
                    if (!ok) begin n_fail++; $display("FAIL b2b_accept[%0d]: not accepted, required accept", i); end
                    else sb.push_back(w);
                end
                @(negedge clk);
                n_tests++;
                if (bus.fifo_level !== 5'(DEPTH)) begin
                    n_fail++;
                    $display("FAIL b2b_level_full: got %0d, required %0d", bus.fifo_level, DEPTH);
                end
                n_tests++;
                if (bus.tx_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_full: got %b, required 0", bus.tx_ready); end
                push_word(8'hAA, FLEN + 8, ok, t_aa);
                n_tests++;
                if (!ok) begin
                    n_fail++;
                    $display("FAIL b2b_aa_accept: not accepted, required accept");
                end else begin
                    sb.push_back(8'hAA);
                end
                release_bus();
                n_tests++;
                if (t_aa - t_lead != (FLEN + 2) * TCLK) begin
                    n_fail++;
                    $display("FAIL b2b_aa_time: got %0t after lead, required %0t", t_aa - t_lead, (FLEN + 2) * TCLK);
                end
            end
        join
        check_idle(FLEN, "b2b_after");
    endtask

    task automatic test_flush();
        logic [DB-1:0] w;
        bit  ok;
        time t_x;
        fork
            monitor_frames(1, 4 * FLEN, 1'b0);
            begin
                for (int i = 0; i < 6; i++) begin
                    w = DB'($urandom);
                    push_word(w, 4, ok, t_x);
                    n_tests++;
                    if (!ok) begin n_fail++; $display("FAIL flush_accept[%0d]: not accepted, required accept", i); end
                    else sb.push_back(w);
                end
                release_bus();
                repeat (40) @(negedge clk);
                bus.tx_flush = 1'b1;
                bus.tx_valid = 1'b1;
                bus.tx_data  = DB'($urandom);
                @(negedge clk);
                bus.tx_flush = 1'b0;
                bus.tx_valid = 1'b0;
                while (sb.size() > 1) void'(sb.pop_back());
                n_tests++;
                if (bus.fifo_level !== 5'd0) begin n_fail++; $display("FAIL flush_level: got %0d, required 0", bus.fifo_level); end
                n_tests++;
                if (bus.tx_busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy: got %b, required 1", bus.tx_busy); end
            end
        join
        check_idle(2 * FLEN, "flush_after");
    endtask

    task automatic test_random();
        logic [DB-1:0] w;
        bit  ok;
        time t_x;
        int  gap;
        fork
            monitor_frames(12, 4 * FLEN, 1'b0);
            begin
                for (int i = 0; i < 12; i++) begin
                    w = DB'($urandom);
                    push_word(w, 4 * FLEN, ok, t_x);
                    n_tests++;
                    if (!ok) begin n_fail++; $display("FAIL random_accept[%0d]: not accepted, required accept", i); end
                    else sb.push_back(w);
                    release_bus();
                    gap = $urandom_range(0, 2 * FLEN);
                    if ($urandom_range(0, 2) == 0) gap = 0;
                    repeat (gap) @(negedge clk);
                end
            end
        join
        check_idle(FLEN, "random_after");
    endtask

    task automatic test_reset_mid_frame();
        logic [DB-1:0] w;
        bit  ok;
        time t_x;
        push_word(8'h00, 4, ok, t_x);
        for (int i = 0; i < 3; i++) begin
            w = DB'($urandom);
            push_word(w, 4, ok, t_x);
        end
        release_bus();
        repeat (3 * CPB) @(negedge clk);
        n_tests++;
        if (bus.tx_serial !== 1'b0 || bus.tx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: got serial %b busy %b, required 0 1", bus.tx_serial, bus.tx_busy);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (bus.tx_serial !== 1'b1) begin n_fail++; $display("FAIL rstmid_serial: got %b, required 1", bus.tx_serial); end
        n_tests++;
        if (bus.tx_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b, required 0", bus.tx_busy); end
        n_tests++;
        if (bus.fifo_level !== 5'd0) begin n_fail++; $display("FAIL rstmid_level: got %0d, required 0", bus.fifo_level); end
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check_idle(2 * FLEN, "rstmid_after");
    endtask

    initial begin
        #(2_000_000 * TCLK);
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        bus.tx_flush = 1'b0;
        test_reset();
        test_single(8'h01);
        test_single(8'h03);
        test_back_to_back();
        test_flush();
        test_random();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
